// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: scanner FSM states,
// key_code constants and the row/column-to-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_A;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_B;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_bcd_entry_if.sv
// Keypad pins plus the decoded BCD/key outputs of keypad_bcd_entry.
// master = the entry block, slave = board/display side.
interface keypad_bcd_entry_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        input  ROW,
        output COL, units, tens, hundreds, thousands, key_valid, key_code
    );

    modport slave (
        output ROW,
        input  COL, units, tens, hundreds, thousands, key_valid, key_code
    );
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner, single-key debouncer and key decoder for a 4x4 matrix.
// key_hit/hit_code are the accept strobe for the current cycle; the parent
// registers them on the same edge as the FSM enters HELD.
// Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
// ROW is expected to be synchronised to CLK before it reaches this block.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_DELAY   = 60,
    parameter int REPEAT_RATE    = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_hit,
    output logic [3:0] hit_code
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 1 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("keypad_scanner: all timing parameters must be >= 1");
    end

    scan_state_t       state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;
    logic [1:0]        first_row;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_next;
    logic              sample;
    logic              any_low;
    logic              held_low;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic [REP_W-1:0] rep_target;
    logic             rep_phase;
    logic             rep_fire;
`endif

    // Sample strobe, row priority encode and the accept decision for this cycle
    always_comb begin
        sample    = (slot_cnt == SLOT_LAST);
        any_low   = (row_n != 4'hF);
        held_low  = ~row_n[row_idx];
        deb_next  = deb_cnt + DEB_ONE;
        first_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_n[r]) first_row = 2'(r);
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next   = rep_cnt + REP_W'(1);
        rep_target = rep_phase ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
        rep_fire   = held_low && (rep_next == rep_target);
`endif
        key_hit  = 1'b0;
        hit_code = key_map(row_idx, col_idx);
        if (sample) begin
            case (state)
                SCAN: begin
                    // A one-sample debounce accepts straight out of SCAN
                    if (any_low && (DEB_TARGET == DEB_ONE)) begin
                        key_hit  = 1'b1;
                        hit_code = key_map(first_row, col_idx);
                    end
                end
                DEBOUNCE: key_hit = held_low && (deb_next == DEB_TARGET);
`ifdef KEYPAD_AUTOREPEAT_EN
                HELD:     key_hit = rep_fire;
`else
                HELD:     key_hit = 1'b0;
`endif
                default:  key_hit = 1'b0;
            endcase
        end
    end

    // Scan/debounce/hold FSM; COL only moves on samples taken in SCAN or on exit to SCAN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= SCAN;
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col_n    <= 4'b1110;
            row_idx  <= 2'd0;
            deb_cnt  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
`endif
        end else begin
            slot_cnt <= sample ? '0 : slot_cnt + SLOT_W'(1);
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (!any_low) begin
                            col_idx <= col_idx + 2'd1;
                            col_n   <= {col_n[2:0], col_n[3]};
                        end else begin
                            row_idx <= first_row;
                            if (DEB_TARGET == DEB_ONE) begin
                                state   <= HELD;
                                deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt   <= '0;
                                rep_phase <= 1'b0;
`endif
                            end else begin
                                state   <= DEBOUNCE;
                                deb_cnt <= DEB_ONE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (held_low) begin
                            if (deb_next == DEB_TARGET) begin
                                state   <= HELD;
                                deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt   <= '0;
                                rep_phase <= 1'b0;
`endif
                            end else begin
                                deb_cnt <= deb_next;
                            end
                        end else begin
                            state   <= SCAN;
                            deb_cnt <= '0;
                            col_idx <= col_idx + 2'd1;
                            col_n   <= {col_n[2:0], col_n[3]};
                        end
                    end
                    HELD: begin
                        if (held_low) begin
                            deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rep_fire) begin
                                rep_cnt   <= '0;
                                rep_phase <= 1'b1;
                            end else begin
                                rep_cnt <= rep_next;
                            end
`endif
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt   <= '0;
                            rep_phase <= 1'b0;
`endif
                            if (deb_next == DEB_TARGET) begin
                                state   <= SCAN;
                                deb_cnt <= '0;
                                col_idx <= col_idx + 2'd1;
                                col_n   <= {col_n[2:0], col_n[3]};
                            end else begin
                                deb_cnt <= deb_next;
                            end
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad to 4-digit BCD entry. Digits shift in from the right,
// A clears, B backspaces; C, D, * and # only report key_valid/key_code.
// Build option: define KEYPAD_AUTOREPEAT_EN to auto-repeat held keys.
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_DELAY   = 60,
    parameter int REPEAT_RATE    = 15
) (
    input  logic                CLK,
    input  logic                RESET,
    keypad_bcd_entry_if.master  bus
);

    logic       key_hit;
    logic [3:0] hit_code;
    logic [3:0] units_q;
    logic [3:0] tens_q;
    logic [3:0] hundreds_q;
    logic [3:0] thousands_q;
    logic       key_valid_q;
    logic [3:0] key_code_q;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_scanner (
        .CLK      (CLK),
        .RESET    (RESET),
        .row_n    (bus.ROW),
        .col_n    (bus.COL),
        .key_hit  (key_hit),
        .hit_code (hit_code)
    );

    // Apply the accepted key to the BCD register on the same edge as key_valid
    always_ff @(posedge CLK) begin
        if (RESET) begin
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            hundreds_q  <= 4'd0;
            thousands_q <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= key_hit;
            if (key_hit) begin
                key_code_q <= hit_code;
                if (hit_code <= 4'd9) begin
                    thousands_q <= hundreds_q;
                    hundreds_q  <= tens_q;
                    tens_q      <= units_q;
                    units_q     <= hit_code;
                end else if (hit_code == KEY_A) begin
                    units_q     <= 4'd0;
                    tens_q      <= 4'd0;
                    hundreds_q  <= 4'd0;
                    thousands_q <= 4'd0;
                end else if (hit_code == KEY_B) begin
                    units_q     <= tens_q;
                    tens_q      <= hundreds_q;
                    hundreds_q  <= thousands_q;
                    thousands_q <= 4'd0;
                end
            end
        end
    end

    assign bus.units     = units_q;
    assign bus.tens      = tens_q;
    assign bus.hundreds  = hundreds_q;
    assign bus.thousands = thousands_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: table of key presses, random presses against a
// decimal-value model, and timed sequences for bounce, multi-key, reset and
// (when KEYPAD_AUTOREPEAT_EN is defined) auto-repeat.
module tb_keypad_bcd_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    typedef struct {
        int          r;
        int          c;
        int          code;
        logic [15:0] bcd;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] pressed;
    logic [15:0] pressed1;
    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    logic [3:0]  last_code = 4'd0;
    int          model_val = 0;
    int          keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    vec_t        tbl [24];

    keypad_bcd_entry_if bus ();
    keypad_bcd_entry_if bus1 ();

    always #5 CLK = ~CLK;

    keypad_bcd_entry #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    keypad_bcd_entry #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1)
    );

    // Board model: a closed switch pulls its row low while its column is driven low
    always_comb begin
        bus.ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            if ((pressed[r*4 +: 4] & ~bus.COL) != 4'h0) bus.ROW[r] = 1'b0;
    end

    always_comb begin
        bus1.ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            if ((pressed1[r*4 +: 4] & ~bus1.COL) != 4'h0) bus1.ROW[r] = 1'b0;
    end

    always @(negedge CLK) begin
        if (bus.key_valid === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            last_code = bus.key_code;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_apply(input int v, input int code);
        if (code <= 9) return (v * 10 + code) % 10000;
        if (code == 10) return 0;
        if (code == 11) return v / 10;
        return v;
    endfunction

    function automatic logic [15:0] bcd_of(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] dut_bcd();
        return {bus.thousands, bus.hundreds, bus.tens, bus.units};
    endfunction

    // Returns at the first negedge after COL switches to target
    task automatic wait_col(input logic [3:0] target);
        int n = 0;
        @(negedge CLK);
        while (bus.COL === target && n < 64) begin @(negedge CLK); n++; end
        while (bus.COL !== target && n < 64) begin @(negedge CLK); n++; end
        check("wait_col", 32'(bus.COL), 32'(target));
    endtask

    task automatic wait_accept(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            if (bus.key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic press_key(input int r, input int c, output int npulse, output int code);
        bit seen;
        pulse_cnt = 0;
        pressed[r*4 + c] = 1'b1;
        wait_accept(seen);
        pressed = '0;
        repeat (30) @(negedge CLK);
        npulse = pulse_cnt;
        code   = int'(last_code);
    endtask

    initial begin
        int  np;
        int  cd;
        int  k;
        bit  seen;

        tbl[0]  = '{0, 0, 1,  16'h0001};
        tbl[1]  = '{0, 1, 2,  16'h0012};
        tbl[2]  = '{0, 2, 3,  16'h0123};
        tbl[3]  = '{1, 0, 4,  16'h1234};
        tbl[4]  = '{1, 1, 5,  16'h2345};
        tbl[5]  = '{1, 2, 6,  16'h3456};
        tbl[6]  = '{0, 3, 10, 16'h0000};
        tbl[7]  = '{0, 0, 1,  16'h0001};
        tbl[8]  = '{0, 1, 2,  16'h0012};
        tbl[9]  = '{0, 2, 3,  16'h0123};
        tbl[10] = '{1, 0, 4,  16'h1234};
        tbl[11] = '{1, 3, 11, 16'h0123};
        tbl[12] = '{0, 3, 10, 16'h0000};
        tbl[13] = '{3, 2, 15, 16'h0000};
        tbl[14] = '{2, 0, 7,  16'h0007};
        tbl[15] = '{3, 0, 14, 16'h0007};
        tbl[16] = '{2, 3, 12, 16'h0007};
        tbl[17] = '{3, 3, 13, 16'h0007};
        tbl[18] = '{3, 1, 0,  16'h0070};
        tbl[19] = '{2, 1, 8,  16'h0708};
        tbl[20] = '{2, 2, 9,  16'h7089};
        tbl[21] = '{1, 3, 11, 16'h0708};
        tbl[22] = '{1, 1, 5,  16'h7085};
        tbl[23] = '{1, 2, 6,  16'h0856};

        RESET    = 1'b1;
        pressed  = '0;
        pressed1 = '0;
        repeat (3) @(negedge CLK);
        check("reset_col", 32'(bus.COL), 32'hE);
        check("reset_bcd", 32'(dut_bcd()), 32'h0);
        check("reset_valid", 32'(bus.key_valid), 32'h0);
        check("reset_code", 32'(bus.key_code), 32'h0);
        check("reset_col_dbs1", 32'(bus1.COL), 32'hE);
        RESET = 1'b0;

        // One-sample debounce: key 1 accepted on the very first sample
        pressed1[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            check("dbs1_valid", 32'(bus1.key_valid), 32'(i == 4));
        end
        check("dbs1_units", 32'(bus1.units), 32'h1);
        check("dbs1_code", 32'(bus1.key_code), 32'h1);
        pressed1 = '0;
        repeat (30) @(negedge CLK);

        for (int i = 0; i < 24; i++) begin
            press_key(tbl[i].r, tbl[i].c, np, cd);
            check("tbl_pulses", 32'(np), 32'h1);
            check("tbl_code", 32'(cd), 32'(tbl[i].code));
            check("tbl_bcd", 32'(dut_bcd()), 32'(tbl[i].bcd));
            model_val = model_apply(model_val, tbl[i].code);
        end

        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(15, 0));
            repeat ($urandom_range(7, 0)) @(negedge CLK);
            press_key(k / 4, k % 4, np, cd);
            model_val = model_apply(model_val, keymap[k]);
            check("rnd_pulses", 32'(np), 32'h1);
            check("rnd_code", 32'(cd), 32'(keymap[k]));
            check("rnd_bcd", 32'(dut_bcd()), 32'(bcd_of(model_val)));
        end

        // Bounce on key 7: two closed samples, one open, then three closed
        pulse_cnt = 0;
        wait_col(4'b1110);
        pressed[8] = 1'b1;
        repeat (8) @(negedge CLK);
        pressed[8] = 1'b0;
        wait_col(4'b1110);
        pressed[8] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            check("bounce_valid", 32'(bus.key_valid), 32'(i == 12));
        end
        pressed = '0;
        repeat (30) @(negedge CLK);
        model_val = model_apply(model_val, 7);
        check("bounce_pulses", 32'(pulse_cnt), 32'h1);
        check("bounce_code", 32'(last_code), 32'h7);
        check("bounce_bcd", 32'(dut_bcd()), 32'(bcd_of(model_val)));

        // Keys 4 and 7 share column 0; key 3 in column 2 joins during the hold
        pulse_cnt = 0;
        pressed[4] = 1'b1;
        pressed[8] = 1'b1;
        wait_accept(seen);
        check("multi_accept", 32'(seen), 32'h1);
        pressed[2] = 1'b1;
        repeat (16) @(negedge CLK);
        pressed = '0;
        repeat (30) @(negedge CLK);
        model_val = model_apply(model_val, 4);
        check("multi_pulses", 32'(pulse_cnt), 32'h1);
        check("multi_code", 32'(last_code), 32'h4);
        check("multi_bcd", 32'(dut_bcd()), 32'(bcd_of(model_val)));

        // Reset while 9 is held, then 9 must pass a full debounce again
        pressed[10] = 1'b1;
        wait_accept(seen);
        check("held9_accept", 32'(seen), 32'h1);
        repeat (6) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_held_col", 32'(bus.COL), 32'hE);
        check("rst_held_bcd", 32'(dut_bcd()), 32'h0);
        check("rst_held_valid", 32'(bus.key_valid), 32'h0);
        check("rst_held_code", 32'(bus.key_code), 32'h0);
        RESET = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            check("rst_reaccept_valid", 32'(bus.key_valid), 32'(i == 20));
        end
        check("rst_reaccept_code", 32'(bus.key_code), 32'h9);
        check("rst_reaccept_bcd", 32'(dut_bcd()), 32'h0009);
        model_val = 9;
        pressed = '0;
        repeat (30) @(negedge CLK);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Hold key 6 for ten samples: accept on 3, repeats on 8 and 10
        pulse_cnt = 0;
        wait_col(4'b1011);
        pressed[6] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            check("rep_valid", 32'(bus.key_valid), 32'(i == 12 || i == 32 || i == 40));
        end
        pressed = '0;
        repeat (30) @(negedge CLK);
        for (int i = 0; i < 3; i++) model_val = model_apply(model_val, 6);
        check("rep_pulses", 32'(pulse_cnt), 32'h3);
        check("rep_code", 32'(last_code), 32'h6);
        check("rep_bcd", 32'(dut_bcd()), 32'(bcd_of(model_val)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
